soc_reset_seq_ctrl: RTL and testbench

//   Reset/enable sequencer in front of a generated SoC top. Synchronises and debounces the

---
 rtl/soc_reset_pkg.sv | 35 +++
 rtl/key_debounce.sv | 44 ++++
 rtl/soc_reset_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_soc_reset_seq_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/soc_reset_pkg.sv
// Shared definitions for the SoC reset sequencer: FSM state encoding,
// default timing constants and a constant-evaluable clog2 helper.
package soc_reset_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 64;
    localparam int DEF_ENA_DELAY       = 8;
    localparam int EVENT_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_BUS_UP = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_e;

    // Bits needed to hold values 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce filter for the active-low push-button.
// The filtered level only moves after DEBOUNCE_CYCLES consecutive agreeing samples.
module key_debounce
    import soc_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic key_db
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] db_cnt;

    // A sample equal to the current filtered level means the pending change
    // was not stable, so the count starts over.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_db   <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            if (key_sync == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/soc_reset_seq_ctrl.sv
// Reset/enable sequencer: merges button, JTAG and software reset requests, stretches
// them into the SoC reset, then releases the bus before enabling the processor.
module soc_reset_seq_ctrl
    import soc_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int ENA_DELAY       = DEF_ENA_DELAY
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   key_n_i,
    input  logic                   jtag_reset_i,
    input  logic                   sw_reset_req_i,
    output logic                   soc_reset_o,
    output logic                   cpu_ena_o,
    output logic                   status_led_o,
    output logic [EVENT_CNT_W-1:0] rst_event_cnt_o
);

    localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, ENA_DELAY) + 1);

    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       ENA_LAST  = CNT_W'(ENA_DELAY - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [EVENT_CNT_W-1:0] EVENT_MAX = '1;
    localparam logic [EVENT_CNT_W-1:0] EVENT_ONE = EVENT_CNT_W'(1);

    logic             key_db;
    logic             jtag_meta;
    logic             jtag_sync;
    logic             req;
    rst_state_e       state;
    rst_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             event_inc;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n_i),
        .key_db  (key_db)
    );

    // JTAG reset is level-held by the debug host, so synchronising is enough.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jtag_meta <= 1'b0;
            jtag_sync <= 1'b0;
        end else begin
            jtag_meta <= jtag_reset_i;
            jtag_sync <= jtag_meta;
        end
    end

    // The software pulse is already in this clock domain and is used directly.
    assign req = ~key_db | jtag_sync | sw_reset_req_i;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        event_inc  = 1'b0;
        case (state)
            ST_HOLD: begin
                if (req) begin
                    cnt_next = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = ST_BUS_UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_BUS_UP: begin
                if (req) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    event_inc  = 1'b1;
                end else if (cnt == ENA_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (req) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    event_inc  = 1'b1;
                end
            end
            default: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            soc_reset_o <= 1'b1;
            cpu_ena_o   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            soc_reset_o <= (state_next == ST_HOLD);
            cpu_ena_o   <= (state_next == ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_event_cnt_o <= '0;
        end else if (event_inc && (rst_event_cnt_o != EVENT_MAX)) begin
            rst_event_cnt_o <= rst_event_cnt_o + EVENT_ONE;
        end
    end

    assign status_led_o = soc_reset_o;

endmodule

// File: tb/tb_soc_reset_seq_ctrl.sv
// Directed self-checking bench for soc_reset_seq_ctrl with short timing parameters
// (debounce 4, hold 8, enable delay 3) and a queue of expected output snapshots.
module tb_soc_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_n_i;
    logic       jtag_reset_i;
    logic       sw_reset_req_i;
    logic       soc_reset_o;
    logic       cpu_ena_o;
    logic       status_led_o;
    logic [7:0] rst_event_cnt_o;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string      tag;
        logic       soc;
        logic       cpu;
        logic [7:0] cnt;
    } expect_t;

    expect_t scoreboard[$];

    soc_reset_seq_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .ENA_DELAY       (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .key_n_i         (key_n_i),
        .jtag_reset_i    (jtag_reset_i),
        .sw_reset_req_i  (sw_reset_req_i),
        .soc_reset_o     (soc_reset_o),
        .cpu_ena_o       (cpu_ena_o),
        .status_led_o    (status_led_o),
        .rst_event_cnt_o (rst_event_cnt_o)
    );

    always #5 clk = ~clk;

    // Processor must never be enabled while the SoC is held in reset.
    always @(negedge clk) begin
        assert_count++;
        assert (!(soc_reset_o === 1'b1 && cpu_ena_o === 1'b1)) else begin
            fail_count++;
            $error("[TB] FAIL cpu_ena_during_reset: soc_reset_o=%0b cpu_ena_o=%0b required not both 1",
                   soc_reset_o, cpu_ena_o);
        end
    end

    task automatic checkOutput();
        expect_t e;
        if (scoreboard.size() == 0) begin
            assert_count++;
            fail_count++;
            $error("[TB] FAIL scoreboard_empty: observed no entry required one entry");
            return;
        end
        e = scoreboard.pop_front();
        assert_count++;
        assert (soc_reset_o === e.soc) else begin
            fail_count++;
            $error("[TB] FAIL %s soc_reset_o: observed=%0b expected=%0b", e.tag, soc_reset_o, e.soc);
        end
        assert_count++;
        assert (cpu_ena_o === e.cpu) else begin
            fail_count++;
            $error("[TB] FAIL %s cpu_ena_o: observed=%0b expected=%0b", e.tag, cpu_ena_o, e.cpu);
        end
        assert_count++;
        assert (status_led_o === e.soc) else begin
            fail_count++;
            $error("[TB] FAIL %s status_led_o: observed=%0b expected=%0b", e.tag, status_led_o, e.soc);
        end
        assert_count++;
        assert (rst_event_cnt_o === e.cnt) else begin
            fail_count++;
            $error("[TB] FAIL %s rst_event_cnt_o: observed=%0d expected=%0d", e.tag, rst_event_cnt_o, e.cnt);
        end
    endtask

    // Drive one input pattern, optionally queue the outputs expected once it has
    // been applied for the given number of clock cycles, then run and compare.
    task automatic applyStimulus(input string tag, input logic rst_val, input logic key_val,
                                 input logic jtag_val, input logic sw_val, input int cycles,
                                 input bit chk, input logic exp_soc, input logic exp_cpu,
                                 input logic [7:0] exp_cnt);
        expect_t e;
        reset_n        = rst_val;
        key_n_i        = key_val;
        jtag_reset_i   = jtag_val;
        sw_reset_req_i = sw_val;
        if (chk) begin
            e.tag = tag;
            e.soc = exp_soc;
            e.cpu = exp_cpu;
            e.cnt = exp_cnt;
            scoreboard.push_back(e);
        end
        repeat (cycles) @(negedge clk);
        if (chk) checkOutput();
    endtask

    initial begin
        int exp_events;

        // Power-on reset and first bring-up
        applyStimulus("reset",        1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 8'd0);
        applyStimulus("hold_7",       1'b1, 1'b1, 1'b0, 1'b0, 7, 1, 1'b1, 1'b0, 8'd0);
        applyStimulus("bus_up",       1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 8'd0);
        applyStimulus("bus_up_2",     1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0, 8'd0);
        applyStimulus("run",          1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 8'd0);
        $display("[TB] bring-up sequence done");

        // Button: short glitch rejected, then a real press
        applyStimulus("glitch_low",   1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 8'd0);
        applyStimulus("glitch_high",  1'b1, 1'b1, 1'b0, 1'b0, 6, 1, 1'b0, 1'b1, 8'd0);
        applyStimulus("press_6",      1'b1, 1'b0, 1'b0, 1'b0, 6, 1, 1'b0, 1'b1, 8'd0);
        applyStimulus("press_7",      1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 8'd1);
        applyStimulus("press_8",      1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 8'd1);
        applyStimulus("release_13",   1'b1, 1'b1, 1'b0, 1'b0, 13, 1, 1'b1, 1'b0, 8'd1);
        applyStimulus("release_bus",  1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 8'd1);
        applyStimulus("release_run",  1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b1, 8'd1);
        $display("[TB] button sequence done");

        // Software reset pulse
        applyStimulus("sw_pulse",     1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 8'd2);
        applyStimulus("sw_hold_7",    1'b1, 1'b1, 1'b0, 1'b0, 7, 1, 1'b1, 1'b0, 8'd2);
        applyStimulus("sw_bus",       1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 8'd2);
        applyStimulus("sw_bus_2",     1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0, 8'd2);
        applyStimulus("sw_run",       1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 8'd2);
        $display("[TB] software reset sequence done");

        // JTAG pulses during HOLD extend the window without counting events
        applyStimulus("jtag_enter",   1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 8'd3);
        for (int p = 0; p < 4; p++) begin
            applyStimulus("jtag_pulse", 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 8'd3);
            applyStimulus("jtag_gap",   1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 1'b1, 1'b0, 8'd3);
        end
        applyStimulus("jtag_tail",    1'b1, 1'b1, 1'b0, 1'b0, 5, 1, 1'b1, 1'b0, 8'd3);
        applyStimulus("jtag_release", 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 8'd3);
        applyStimulus("jtag_run",     1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b1, 8'd3);
        $display("[TB] jtag sequence done");

        // Block reset while in BUS_UP wipes the sequence and the event count
        applyStimulus("pre_rst_sw",   1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 8'd4);
        applyStimulus("pre_rst_bus",  1'b1, 1'b1, 1'b0, 1'b0, 8, 1, 1'b0, 1'b0, 8'd4);
        applyStimulus("rst_in_bus",   1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 8'd0);
        applyStimulus("rst_hold_7",   1'b1, 1'b1, 1'b0, 1'b0, 7, 1, 1'b1, 1'b0, 8'd0);
        applyStimulus("rst_bus_up",   1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 8'd0);
        applyStimulus("rst_run",      1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b1, 8'd0);
        $display("[TB] mid-sequence reset done");

        // Event counter saturation over 300 full reset cycles
        for (int i = 0; i < 300; i++) begin
            exp_events = (i + 1 > 255) ? 255 : i + 1;
            applyStimulus("sat_pulse", 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 8'd0);
            applyStimulus("sat_run",   1'b1, 1'b1, 1'b0, 1'b0, 11,
                          (i == 0 || i == 253 || i == 254 || i == 255 || i == 299),
                          1'b0, 1'b1, 8'(exp_events));
        end
        $display("[TB] saturation sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
